// File: rtl/ge_arbiter_pkg.sv
// ge_arbiter_pkg: shared defaults for the ge_arbiter slice.
//   GE_NUM_REQ  default requester count
//   GE_WIDTH    default operand width
//   GE_LATENCY  default comparator clock-to-result latency
//   GE_ID_W     requester ID width for the default requester count
//   GE_TOT_LAT  accept-to-response latency (issue register + comparator)
//   ge_id_w()   ID width for any requester count (never below 1 bit)
package ge_arbiter_pkg;

  localparam int unsigned GE_NUM_REQ = 4;
  localparam int unsigned GE_WIDTH   = 32;
  localparam int unsigned GE_LATENCY = 1;

  // ID width helper: clog2, but at least one bit so a 1-wide field is always legal
  function automatic int unsigned ge_id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned GE_ID_W    = ge_id_w(GE_NUM_REQ);
  localparam int unsigned GE_TOT_LAT = GE_LATENCY + 1;

endpackage

// File: rtl/ge.sv
// ge: shared unsigned greater-or-equal comparator, z = (a >= b), delayed by
// LATENCY register stages.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   a, b   WIDTH-bit unsigned operands
//   z      comparison result, LATENCY cycles after a/b are presented
module ge #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             z
);

  logic [LATENCY-1:0] r_pipe;

  // Compare, then carry the result down the latency pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= (a >= b);
      for (int unsigned s = 1; s < LATENCY; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
    end
  end

  assign z = r_pipe[LATENCY-1];

endmodule

// File: rtl/ge_rr_pick.sv
// ge_rr_pick: combinational round-robin picker.
// Searches i_req starting at i_ptr and wrapping modulo NUM_REQ; the first set
// bit wins.
// Optional feature (macro GE_ARB_PRIO0_EN): requester 0 wins whenever it
// requests, and the rotation only covers requesters 1..NUM_REQ-1.
//   i_req      per-requester request vector
//   i_ptr      rotation start index
//   o_grant_c  one-hot grant (zero when nothing requests)
//   o_idx_c    encoded index of the granted requester
//   o_any_c    a grant was made
module ge_rr_pick
  import ge_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = GE_NUM_REQ,
  parameter int unsigned ID_W    = ge_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [ID_W-1:0]    o_idx_c,
  output logic               o_any_c
);

  logic [NUM_REQ-1:0] w_rr_req;

  // Offset-ordered search; indices stay constant so no variable bit-selects
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    w_rr_req  = i_req;
`ifdef GE_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation entirely
    w_rr_req[0] = 1'b0;
    if (i_req[0]) begin
      o_grant_c[0] = 1'b1;
      o_any_c      = 1'b1;
    end
`endif
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!o_any_c && w_rr_req[i] && (((32'(i_ptr) + off) % NUM_REQ) == i)) begin
          o_grant_c[i] = 1'b1;
          o_idx_c      = ID_W'(i);
          o_any_c      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ge_arbiter.sv
// ge_arbiter: shares one `ge` comparator among NUM_REQ requesters.
// One round-robin grant per cycle; the granted operands and ID are registered
// into the issue stage, the ID rides a tag pipe alongside the comparator, and
// the result is returned as a one-hot strobe to its owner TOT_LAT cycles after
// acceptance.
// Optional feature: macro GE_ARB_PRIO0_EN gives requester 0 fixed top priority
// (handled inside ge_rr_pick; the pointer does not move on its grants).
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   i_req_valid   per-requester request strobe
//   o_req_ready   one-hot grant (combinational), zero while in reset
//   i_req_a       flattened operand a, requester i at [i*WIDTH +: WIDTH]
//   i_req_b       flattened operand b, same packing
//   o_resp_valid  one-hot one-cycle result strobe
//   o_resp_z      comparison result, holds when o_resp_valid is zero
//   o_resp_id     owner of o_resp_z, holds when o_resp_valid is zero
//   o_busy        a comparison is in flight
module ge_arbiter
  import ge_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = GE_NUM_REQ,
  parameter int unsigned WIDTH   = GE_WIDTH,
  parameter int unsigned LATENCY = GE_LATENCY,
  parameter int unsigned ID_W    = ge_id_w(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]         o_resp_valid,
  output logic                       o_resp_z,
  output logic [ID_W-1:0]            o_resp_id,
  output logic                       o_busy
);

  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_xfer;
  logic [ID_W-1:0]    w_ptr_next;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;

  logic               r_issue_v;
  logic [ID_W-1:0]    r_issue_id;
  logic [WIDTH-1:0]   r_issue_a;
  logic [WIDTH-1:0]   r_issue_b;

  logic [LATENCY-1:0] r_tag_v;
  logic [ID_W-1:0]    r_tag_id [LATENCY];

  logic               w_z;

  logic [NUM_REQ-1:0] r_resp_valid;
  logic               r_resp_z;
  logic [ID_W-1:0]    r_resp_id;

  // Round-robin selection
  ge_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req     (i_req_valid),
    .i_ptr     (r_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx),
    .o_any_c   (w_any)
  );

  // Grants are suppressed while reset is asserted
  assign o_req_ready = rst_n ? w_grant : '0;
  assign w_xfer      = w_any & rst_n;
  assign w_ptr_next  = (32'(w_idx) == (NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);

  // Operand mux for the granted requester (grant is one-hot)
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_a = i_req_a[i*WIDTH +: WIDTH];
        w_b = i_req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Rotation pointer: moves past the last granted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
`ifdef GE_ARB_PRIO0_EN
      if (w_idx != '0) begin
        r_ptr <= w_ptr_next;
      end
`else
      r_ptr <= w_ptr_next;
`endif
    end
  end

  // Issue stage: operands and ID hold their last value when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_v  <= 1'b0;
      r_issue_id <= '0;
      r_issue_a  <= '0;
      r_issue_b  <= '0;
    end else begin
      r_issue_v <= w_xfer;
      if (w_xfer) begin
        r_issue_id <= w_idx;
        r_issue_a  <= w_a;
        r_issue_b  <= w_b;
      end
    end
  end

  // Shared comparator
  ge #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_ge (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (r_issue_a),
    .b     (r_issue_b),
    .z     (w_z)
  );

  // Tag pipe, same depth as the comparator so tags line up with results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v <= '0;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_v[0]  <= r_issue_v;
      r_tag_id[0] <= r_issue_id;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // Response register: strobe is one cycle, z/id hold between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= '0;
      r_resp_z     <= 1'b0;
      r_resp_id    <= '0;
    end else begin
      r_resp_valid <= '0;
      if (r_tag_v[LATENCY-1]) begin
        r_resp_valid <= NUM_REQ'(1) << r_tag_id[LATENCY-1];
        r_resp_z     <= w_z;
        r_resp_id    <= r_tag_id[LATENCY-1];
      end
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_z     = r_resp_z;
  assign o_resp_id    = r_resp_id;
  assign o_busy       = r_issue_v | (|r_tag_v);

endmodule

// File: tb/tb_ge_arbiter.sv
// tb_ge_arbiter: self-checking bench for ge_arbiter with a queue-based
// reference model (pick rule, pending-result queue with due cycles).
module tb_ge_arbiter;
  import ge_arbiter_pkg::*;

  localparam int unsigned N   = GE_NUM_REQ;
  localparam int unsigned W   = GE_WIDTH;
  localparam int unsigned IDW = GE_ID_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       i_req_valid = '0;
  logic [N-1:0]       o_req_ready;
  logic [N*W-1:0]     i_req_a = '0;
  logic [N*W-1:0]     i_req_b = '0;
  logic [N-1:0]       o_resp_valid;
  logic               o_resp_z;
  logic [IDW-1:0]     o_resp_id;
  logic               o_busy;

  always #5 clk = ~clk;

  ge_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_a      (i_req_a),
    .i_req_b      (i_req_b),
    .o_resp_valid (o_resp_valid),
    .o_resp_z     (o_resp_z),
    .o_resp_id    (o_resp_id),
    .o_busy       (o_busy)
  );

  typedef struct {
    int unsigned id;
    logic        z;
    int unsigned due;
  } item_t;

  item_t       q[$];
  int unsigned ptr;
  int unsigned cyc;
  logic [N-1:0] m_rv;
  logic        m_z;
  int unsigned m_id;
  int          total = 0;
  int          bad = 0;

  // Spec pick rule; returns -1 when nothing is requesting
  function automatic int model_pick(input logic [N-1:0] v);
    logic [N-1:0] sh;
`ifdef GE_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int o = 0; o < int'(N); o++) begin
      int c;
      c = (int'(ptr) + o) % int'(N);
      sh = v >> c;
`ifdef GE_ARB_PRIO0_EN
      if (c != 0 && sh[0]) return c;
`else
      if (sh[0]) return c;
`endif
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] put(input logic [N*W-1:0] vec, input int idx,
                                         input logic [W-1:0] val);
    logic [N*W-1:0] m;
    m = (N*W)'({W{1'b1}}) << (idx * W);
    return (vec & ~m) | ((N*W)'(val) << (idx * W));
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(32'h8000_0000);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check, then advance the model over the posedge
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    int g;
    logic [N-1:0] eg;
    logic [W-1:0] aa;
    logic [W-1:0] bb;
    i_req_valid = v;
    i_req_a     = a;
    i_req_b     = b;
    #1;
    g  = model_pick(v);
    eg = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready",  64'(o_req_ready),  64'(eg));
    chk("resp_valid", 64'(o_resp_valid), 64'(m_rv));
    chk("resp_z",     64'(o_resp_z),     64'(m_z));
    chk("resp_id",    64'(o_resp_id),    64'(m_id));
    chk("busy",       64'(o_busy),       64'(q.size() != 0));
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      aa = W'(a >> (g * W));
      bb = W'(b >> (g * W));
      q.push_back('{id: int'(g), z: (aa >= bb), due: cyc + GE_TOT_LAT});
`ifdef GE_ARB_PRIO0_EN
      if (g != 0) ptr = (int'(g) + 1) % N;
`else
      ptr = (int'(g) + 1) % N;
`endif
    end
    m_rv = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      m_rv = N'(1) << q[0].id;
      m_z  = q[0].z;
      m_id = q[0].id;
      void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0);
  endtask

  // Reset with all requests raised: grants must stay low, outputs clear at once
  task automatic do_reset();
    rst_n       = 1'b0;
    i_req_valid = '1;
    #1;
    q.delete();
    ptr  = 0;
    m_rv = '0;
    m_z  = 1'b0;
    m_id = 0;
    chk("rst_req_ready",  64'(o_req_ready),  64'(0));
    chk("rst_resp_valid", 64'(o_resp_valid), 64'(0));
    chk("rst_resp_z",     64'(o_resp_z),     64'(0));
    chk("rst_resp_id",    64'(o_resp_id),    64'(0));
    chk("rst_busy",       64'(o_busy),       64'(0));
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n       = 1'b1;
    i_req_valid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    cyc = 0;
    @(negedge clk);
    do_reset();

    // Single request, equal operands
    step(N'(4'b0010), put('0, 1, W'(7)), put('0, 1, W'(7)));
    idle(3);

    // All requesters valid for 8 cycles
    for (int k = 0; k < 8; k++) begin
      a = '0;
      b = '0;
      for (int r = 0; r < int'(N); r++) begin
        a = put(a, r, rnd_val());
        b = put(b, r, rnd_val());
      end
      step('1, a, b);
    end
    idle(3);

    // Boundary operands on requester 2
    step(N'(4'b0100), put('0, 2, W'(0)), put('0, 2, '1));
    step(N'(4'b0100), put('0, 2, '1), put('0, 2, W'(0)));
    step(N'(4'b0100), put('0, 2, W'(32'h8000_0000)), put('0, 2, W'(32'h8000_0000)));
    idle(3);

    // Pointer hold and wrap
    step(N'(4'b1000), '0, '0);
    idle(2);
    step(N'(4'b1001), '0, '0);
    step(N'(4'b1001), '0, '0);
    idle(3);

    // Reset while a comparison is in flight
    step(N'(4'b0100), put('0, 2, W'(9)), put('0, 2, W'(3)));
    do_reset();
    idle(3);
    step('1, '0, '0);
    idle(3);

    // Full load, then requester 0 drops out
    for (int k = 0; k < 4; k++) step('1, '1, '0);
    for (int k = 0; k < 4; k++) step(N'(4'b1110), '0, '1);
    idle(3);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      logic [N-1:0] v;
      v = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
      a = '0;
      b = '0;
      for (int r = 0; r < int'(N); r++) begin
        b = put(b, r, rnd_val());
        a = put(a, r, ($urandom_range(0, 3) == 0) ? W'(b >> (r * W)) : rnd_val());
      end
      step(v, a, b);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
